// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding, default timing
// and the bit-sampling helper used by the receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DEF_CLK_DIV    = 54;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every CLK_DIV clocks, shared by
// the UART receiver and transmitter.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Down-counter with reload; the tick flop mirrors a zero count so the output is registered.
  always_comb begin
    cnt_d  = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
    tick_d = (cnt_d == '0);
  end

  // Counter and tick registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= RELOAD;
      tick_q <= (RELOAD == '0);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-FF synchroniser, 3-sample majority vote per bit,
// start-glitch rejection, optional parity and one or two stop bits.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_serial_data,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int M    = OVERSAMPLE / 2;
  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam int BI_W = $clog2(DATA_BITS);

  localparam logic [PH_W-1:0] PH_S0   = PH_W'(M - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(M);
  localparam logic [PH_W-1:0] PH_DEC  = PH_W'(M + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);
  localparam logic            ST_LAST = 1'(STOP_BITS - 1);

  logic                 tick_s, rx_s, maj_s, dec_s, wrap_s, ones_odd_s;
  logic                 sync1_q, sync2_q;
  rx_state_e            state_q, state_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [BI_W-1:0]      bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 perr_acc_q, perr_acc_d, ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, busy_q, busy_d;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick_s)
  );

  assign rx_s       = sync2_q;
  assign dec_s      = (ph_q == PH_DEC);
  assign wrap_s     = (ph_q == PH_LAST);
  // The third sample is the live line value on the decision tick.
  assign maj_s      = maj3(samp_q[0], samp_q[1], rx_s);
  assign ones_odd_s = ^{shift_q, maj_s};

  // Receive FSM: all state changes happen on oversample ticks only.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;
    if (tick_s) begin
      if (ph_q == PH_S0) samp_d[0] = rx_s;
      else if (ph_q == PH_S1) samp_d[1] = rx_s;
      else samp_d = samp_q;
      ph_d = wrap_s ? '0 : ph_q + PH_W'(1);
      case (state_q)
        RX_IDLE: begin
          // The detecting tick counts as phase 0 of the start bit.
          if (!rx_s) begin
            state_d    = RX_START;
            ph_d       = PH_W'(1);
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
          end else begin
            ph_d = ph_q;
          end
        end
        RX_START: begin
          if (dec_s && maj_s) begin
            state_d = RX_IDLE;
            ph_d    = '0;
          end else if (wrap_s) begin
            state_d = RX_DATA;
            bit_d   = '0;
          end else begin
            state_d = RX_START;
          end
        end
        RX_DATA: begin
          if (dec_s) shift_d = {maj_s, shift_q[DATA_BITS-1:1]};
          else shift_d = shift_q;
          if (wrap_s && bit_q == BI_LAST) begin
            state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            stop_d  = 1'b0;
          end else if (wrap_s) begin
            bit_d = bit_q + BI_W'(1);
          end else begin
            bit_d = bit_q;
          end
        end
        RX_PARITY: begin
          if (dec_s) begin
            perr_acc_d = (PARITY == PAR_ODD) ? ~ones_odd_s : ones_odd_s;
          end else if (wrap_s) begin
            state_d = RX_STOP;
            stop_d  = 1'b0;
          end else begin
            perr_acc_d = perr_acc_q;
          end
        end
        RX_STOP: begin
          // Publish at the last stop-bit decision so the next start edge is not missed.
          if (dec_s && stop_q == ST_LAST) begin
            state_d = RX_IDLE;
            ph_d    = '0;
            valid_d = 1'b1;
            data_d  = shift_q;
            perr_d  = perr_acc_q;
            ferr_d  = ferr_acc_q | ~maj_s;
          end else if (dec_s) begin
            ferr_acc_d = ferr_acc_q | ~maj_s;
          end else if (wrap_s) begin
            stop_d = stop_q + 1'b1;
          end else begin
            stop_d = stop_q;
          end
        end
        default: begin
          state_d = RX_IDLE;
          ph_d    = '0;
        end
      endcase
    end else begin
      valid_d = 1'b0;
    end
    busy_d = (state_d != RX_IDLE);
  end

  // Synchroniser, FSM state and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= RX_IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      samp_q     <= 2'b11;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= i_rx_serial_data;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign o_rx_data    = data_q;
  assign o_rx_valid   = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four receiver configurations (8N1, 8E1, 8N2, 7O1)
// on separate serial lines, CLK_DIV=4 and OVERSAMPLE=16 so one bit is 64 clocks.
module tb_uart_rx_cfg;

  localparam int CLK_DIV  = 4;
  localparam int OS       = 16;
  localparam int BIT_CLKS = CLK_DIV * OS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rx  = 4'hF;

  logic [7:0] d_8n1, d_8e1, d_8n2;
  logic [6:0] d_7o1;
  logic v_8n1, pe_8n1, fe_8n1, b_8n1;
  logic v_8e1, pe_8e1, fe_8e1, b_8e1;
  logic v_8n2, pe_8n2, fe_8n2, b_8n2;
  logic v_7o1, pe_7o1, fe_7o1, b_7o1;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_clk(clk), .i_rst(rst), .i_rx_serial_data(rx[0]), .o_rx_data(d_8n1), .o_rx_valid(v_8n1),
    .o_parity_err(pe_8n1), .o_frame_err(fe_8n1), .o_busy(b_8n1));
  uart_rx_cfg #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .i_clk(clk), .i_rst(rst), .i_rx_serial_data(rx[1]), .o_rx_data(d_8e1), .o_rx_valid(v_8e1),
    .o_parity_err(pe_8e1), .o_frame_err(fe_8e1), .o_busy(b_8e1));
  uart_rx_cfg #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .i_clk(clk), .i_rst(rst), .i_rx_serial_data(rx[2]), .o_rx_data(d_8n2), .o_rx_valid(v_8n2),
    .o_parity_err(pe_8n2), .o_frame_err(fe_8n2), .o_busy(b_8n2));
  uart_rx_cfg #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7o1 (
    .i_clk(clk), .i_rst(rst), .i_rx_serial_data(rx[3]), .o_rx_data(d_7o1), .o_rx_valid(v_7o1),
    .o_parity_err(pe_7o1), .o_frame_err(fe_7o1), .o_busy(b_7o1));

  int         nvec = 0;
  int         nerr = 0;
  int         cnt[4];
  logic [8:0] last_d[4];
  logic       last_pe[4];
  logic       last_fe[4];
  logic [6:0] cap7[$];
  bit         busy_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe capture for every receiver, sampled away from the active edge.
  always @(negedge clk) begin
    if (v_8n1) begin cnt[0]++; last_d[0] = {1'b0, d_8n1}; last_pe[0] = pe_8n1; last_fe[0] = fe_8n1; end
    if (v_8e1) begin cnt[1]++; last_d[1] = {1'b0, d_8e1}; last_pe[1] = pe_8e1; last_fe[1] = fe_8e1; end
    if (v_8n2) begin cnt[2]++; last_d[2] = {1'b0, d_8n2}; last_pe[2] = pe_8n2; last_fe[2] = fe_8n2; end
    if (v_7o1) begin cnt[3]++; last_d[3] = 9'(d_7o1); last_pe[3] = pe_7o1; last_fe[3] = fe_7o1; cap7.push_back(d_7o1); end
    if (b_8n1) busy_seen = 1'b1;
  end

  function automatic logic [15:0] mk_frame(input logic [8:0] d, input int nd, input int has_p,
                                          input logic p, input logic [1:0] stops, input int ns);
    logic [15:0] f;
    int k;
    f = 16'hFFFF;
    f[0] = 1'b0;
    for (int i = 0; i < nd; i++) f[1+i] = d[i];
    k = 1 + nd;
    if (has_p != 0) begin f[k] = p; k++; end
    for (int i = 0; i < ns; i++) f[k+i] = stops[i];
    return f;
  endfunction

  task automatic send(input int idx, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rx[idx] = f[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx[idx] = 1'b1;
  endtask

  // Invert the line for one clock so that only the centre sample of data bit 3 sees it.
  task automatic glitch_bit3();
    int t;
    t = 0;
    while (!b_8n1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("glitch_start_seen", 32'(b_8n1), 32'd1);
    if (b_8n1) begin
      repeat (285) @(posedge clk);
      @(negedge clk) rx[0] = 1'b0;
      @(negedge clk) rx[0] = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; last_d[i] = '0; last_pe[i] = 1'b0; last_fe[i] = 1'b0; end
    busy_seen = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_data", 32'(d_8n1), 32'h0);
    chk("rst_valid", 32'(v_8n1), 32'h0);
    chk("rst_flags", {30'd0, pe_8e1, fe_8n2}, 32'h0);
    chk("rst_busy", 32'(b_7o1), 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 8N1 0xA5
    send(0, mk_frame(9'h0A5, 8, 0, 1'b0, 2'b11, 1), 10);
    repeat (100) @(negedge clk);
    chk("8n1_cnt", 32'(cnt[0]), 32'd1);
    chk("8n1_data", 32'(last_d[0]), 32'hA5);
    chk("8n1_flags", {30'd0, last_pe[0], last_fe[0]}, 32'h0);
    chk("8n1_busy_idle", 32'(b_8n1), 32'h0);

    // 8E1 0x37: five ones, so the even-parity bit is 1
    send(1, mk_frame(9'h037, 8, 1, 1'b1, 2'b11, 1), 11);
    repeat (100) @(negedge clk);
    chk("8e1_good_cnt", 32'(cnt[1]), 32'd1);
    chk("8e1_good_data", 32'(last_d[1]), 32'h37);
    chk("8e1_good_perr", 32'(last_pe[1]), 32'h0);
    send(1, mk_frame(9'h037, 8, 1, 1'b0, 2'b11, 1), 11);
    repeat (100) @(negedge clk);
    chk("8e1_bad_cnt", 32'(cnt[1]), 32'd2);
    chk("8e1_bad_data", 32'(last_d[1]), 32'h37);
    chk("8e1_bad_perr", 32'(last_pe[1]), 32'h1);
    chk("8e1_bad_ferr", 32'(last_fe[1]), 32'h0);

    // 8N2 with the second stop bit low
    send(2, mk_frame(9'h03C, 8, 0, 1'b0, 2'b01, 2), 11);
    repeat (200) @(negedge clk);
    chk("8n2_cnt", 32'(cnt[2]), 32'd1);
    chk("8n2_data", 32'(last_d[2]), 32'h3C);
    chk("8n2_ferr", 32'(last_fe[2]), 32'h1);
    chk("8n2_perr", 32'(last_pe[2]), 32'h0);

    // 20-clock low pulse is rejected as a start glitch
    busy_seen = 1'b0;
    rx[0] = 1'b0;
    repeat (20) @(negedge clk);
    rx[0] = 1'b1;
    repeat (150) @(negedge clk);
    chk("glitch_busy_pulse", 32'(busy_seen), 32'h1);
    chk("glitch_no_strobe", 32'(cnt[0]), 32'd1);
    chk("glitch_busy_low", 32'(b_8n1), 32'h0);
    send(0, mk_frame(9'h05A, 8, 0, 1'b0, 2'b11, 1), 10);
    repeat (100) @(negedge clk);
    chk("after_glitch_cnt", 32'(cnt[0]), 32'd2);
    chk("after_glitch_data", 32'(last_d[0]), 32'h5A);

    // Majority vote masks a one-clock glitch on the centre sample of bit 3
    fork
      send(0, mk_frame(9'h0FF, 8, 0, 1'b0, 2'b11, 1), 10);
      glitch_bit3();
    join
    repeat (100) @(negedge clk);
    chk("maj_cnt", 32'(cnt[0]), 32'd3);
    chk("maj_data", 32'(last_d[0]), 32'hFF);
    chk("maj_ferr", 32'(last_fe[0]), 32'h0);

    // 7O1 back-to-back: 0x41 has two ones (parity 1), 0x7F has seven (parity 0)
    send(3, mk_frame(9'h041, 7, 1, 1'b1, 2'b11, 1), 10);
    send(3, mk_frame(9'h07F, 7, 1, 1'b0, 2'b11, 1), 10);
    repeat (100) @(negedge clk);
    chk("b2b_cnt", 32'(cnt[3]), 32'd2);
    chk("b2b_first", 32'(cap7[0]), 32'h41);
    chk("b2b_second", 32'(cap7[1]), 32'h7F);
    chk("b2b_perr", 32'(last_pe[3]), 32'h0);

    // Same pair again, reset partway through the second frame
    send(3, mk_frame(9'h041, 7, 1, 1'b1, 2'b11, 1), 10);
    send(3, mk_frame(9'h07F, 7, 1, 1'b0, 2'b11, 1), 5);
    chk("mid_busy", 32'(b_7o1), 32'h1);
    chk("mid_first_data", 32'(cap7[2]), 32'h41);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_data", 32'(d_7o1), 32'h0);
    chk("mrst_outs", {28'd0, v_7o1, pe_7o1, fe_7o1, b_7o1}, 32'h0);
    repeat (800) @(negedge clk);
    chk("mrst_no_strobe", 32'(cnt[3]), 32'd3);
    chk("mrst_data_hold", 32'(d_7o1), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
